// File: rtl/mem_arbiter.sv
// Two-master arbiter: shares one memory bus between the I-cache refill port and
// the data-memory port. Round-robin on ties, one transaction in flight, optional DM lock.
module mem_arbiter #(
  parameter int         XLEN  = 32,
  parameter logic [2:0] IC_F3 = 3'b010
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ic_req,
  input  logic [XLEN-1:0] i_ic_addr,
  output logic [XLEN-1:0] o_ic_data,
  output logic            o_ic_ready,
  input  logic            i_dm_req,
  input  logic            i_dm_wen,
  input  logic [XLEN-1:0] i_dm_addr,
  input  logic [XLEN-1:0] i_dm_wd,
  input  logic [2:0]      i_dm_f3,
  input  logic            i_dm_lock,
  output logic [XLEN-1:0] o_dm_rdata,
  output logic            o_dm_ready,
  output logic            o_mem_req,
  output logic            o_mem_wen,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wd,
  output logic [2:0]      o_mem_f3,
  input  logic            i_mem_ready,
  input  logic [XLEN-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, IC_BUSY, DM_BUSY, RESP} state_e;
  typedef enum logic {GNT_IC, GNT_DM} side_e;

  state_e          state_q, state_d;
  side_e           last_q;
  logic            lock_q, dm_lock_q;
  logic [XLEN-1:0] addr_q, wd_q, ic_data_q, dm_data_q;
  logic [2:0]      f3_q;
  logic            wen_q;
  logic            grant_ic, grant_dm;

  // Grants are only made from IDLE; a held lock shuts the I-cache out entirely.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_ic = 1'b0;
    grant_dm = 1'b0;
    if (state_q == IDLE) begin
      if (lock_q) begin
        grant_dm = i_dm_req;
      end else if (i_ic_req && i_dm_req) begin
        grant_ic = (last_q == GNT_DM);
        grant_dm = (last_q == GNT_IC);
      end else begin
        grant_ic = i_ic_req;
        grant_dm = i_dm_req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_ic)      state_d = IC_BUSY;
        else if (grant_dm) state_d = DM_BUSY;
      end
      IC_BUSY, DM_BUSY: if (i_mem_ready) state_d = RESP;
      RESP:             state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_q    <= GNT_IC;
      lock_q    <= 1'b0;
      dm_lock_q <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      f3_q      <= '0;
      wen_q     <= 1'b0;
      ic_data_q <= '0;
      dm_data_q <= '0;
    end else begin
      if (grant_ic) begin
        addr_q <= i_ic_addr;
        wd_q   <= '0;
        f3_q   <= IC_F3;
        wen_q  <= 1'b0;
        last_q <= GNT_IC;
      end else if (grant_dm) begin
        addr_q    <= i_dm_addr;
        wd_q      <= i_dm_wd;
        f3_q      <= i_dm_f3;
        wen_q     <= i_dm_wen;
        last_q    <= GNT_DM;
        dm_lock_q <= i_dm_lock;
      end
      if (i_mem_ready && state_q == IC_BUSY) ic_data_q <= i_mem_rdata;
      // Lock takes effect once the atomic's access completes and persists until a non-locked DM access completes.
      if (i_mem_ready && state_q == DM_BUSY) begin
        dm_data_q <= i_mem_rdata;
        lock_q    <= dm_lock_q;
      end
    end
  end

  assign o_mem_req  = (state_q == IC_BUSY) || (state_q == DM_BUSY);
  assign o_mem_wen  = wen_q;
  assign o_mem_addr = addr_q;
  assign o_mem_wd   = wd_q;
  assign o_mem_f3   = f3_q;
  assign o_ic_ready = (state_q == RESP) && (last_q == GNT_IC);
  assign o_dm_ready = (state_q == RESP) && (last_q == GNT_DM);
  assign o_ic_data  = ic_data_q;
  assign o_dm_rdata = dm_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, lock and returned data.
module tb_mem_arbiter;
  localparam int         XLEN  = 32;
  localparam logic [2:0] IC_F3 = 3'b010;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_ic_req, i_dm_req, i_dm_wen, i_dm_lock, i_mem_ready;
  logic [XLEN-1:0] i_ic_addr, i_dm_addr, i_dm_wd, i_mem_rdata;
  logic [2:0]      i_dm_f3;
  logic [XLEN-1:0] o_ic_data, o_dm_rdata, o_mem_addr, o_mem_wd;
  logic            o_ic_ready, o_dm_ready, o_mem_req, o_mem_wen;
  logic [2:0]      o_mem_f3;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: who was served last, whether the data side holds the bus, last data returned.
  bit              last_dm_m;
  bit              lock_m;
  logic [XLEN-1:0] ic_data_m, dm_data_m;

  mem_arbiter #(.XLEN(XLEN), .IC_F3(IC_F3)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_ic_req(i_ic_req), .i_ic_addr(i_ic_addr), .o_ic_data(o_ic_data), .o_ic_ready(o_ic_ready),
    .i_dm_req(i_dm_req), .i_dm_wen(i_dm_wen), .i_dm_addr(i_dm_addr), .i_dm_wd(i_dm_wd),
    .i_dm_f3(i_dm_f3), .i_dm_lock(i_dm_lock), .o_dm_rdata(o_dm_rdata), .o_dm_ready(o_dm_ready),
    .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr), .o_mem_wd(o_mem_wd),
    .o_mem_f3(o_mem_f3), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_dm_m = 1'b0;
    lock_m    = 1'b0;
    ic_data_m = '0;
    dm_data_m = '0;
  endtask

  // 0 = nobody, 1 = I-cache, 2 = data side.
  function automatic int pick(input bit ic, input bit dm);
    if (lock_m) return dm ? 2 : 0;
    if (ic && dm) return last_dm_m ? 1 : 2;
    if (ic) return 1;
    if (dm) return 2;
    return 0;
  endfunction

  task automatic set_dm(input bit wen, input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wd,
                        input logic [2:0] f3, input bit lock);
    i_dm_req  = 1'b1;
    i_dm_wen  = wen;
    i_dm_addr = addr;
    i_dm_wd   = wd;
    i_dm_f3   = f3;
    i_dm_lock = lock;
  endtask

  // Called from IDLE with requests already driven; runs one arbitration round and checks every cycle.
  task automatic run_grant(input int waits, input logic [XLEN-1:0] rd);
    int              who;
    logic [XLEN-1:0] e_addr, e_wd;
    logic [2:0]      e_f3;
    logic            e_wen;
    bit              e_lock;
    who    = pick(i_ic_req, i_dm_req);
    e_addr = (who == 1) ? i_ic_addr : i_dm_addr;
    e_wd   = i_dm_wd;
    e_f3   = (who == 1) ? IC_F3 : i_dm_f3;
    e_wen  = (who == 2) && i_dm_wen;
    e_lock = i_dm_lock;
    step();
    if (who == 0) begin
      n_total++;
      if (o_mem_req !== 1'b0 || o_ic_ready !== 1'b0 || o_dm_ready !== 1'b0)
        $display("FAIL no_grant: mem_req=%b ic_ready=%b dm_ready=%b, required all 0",
                 o_mem_req, o_ic_ready, o_dm_ready);
      else n_pass++;
      return;
    end
    for (int c = 0; c <= waits; c++) begin
      n_total++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== e_addr || o_mem_f3 !== e_f3 || o_mem_wen !== e_wen ||
          (who == 2 && o_mem_wd !== e_wd) || o_ic_ready !== 1'b0 || o_dm_ready !== 1'b0)
        $display("FAIL busy_side%0d_c%0d: req=%b addr=%h f3=%b wen=%b wd=%h rdy=%b%b, required req=1 addr=%h f3=%b wen=%b wd=%h rdy=00",
                 who, c, o_mem_req, o_mem_addr, o_mem_f3, o_mem_wen, o_mem_wd, o_ic_ready, o_dm_ready,
                 e_addr, e_f3, e_wen, e_wd);
      else n_pass++;
      // The granted requester may change its inputs or drop req; the bus must not notice.
      if (who == 1) begin
        i_ic_addr = $urandom;
        i_ic_req  = 1'($urandom_range(0, 1));
      end else begin
        i_dm_addr = $urandom;
        i_dm_wd   = $urandom;
        i_dm_f3   = 3'($urandom);
        i_dm_wen  = 1'($urandom);
        i_dm_lock = 1'($urandom);
        i_dm_req  = 1'($urandom_range(0, 1));
      end
      i_mem_ready = (c == waits);
      i_mem_rdata = (c == waits) ? rd : $urandom;
      step();
    end
    if (who == 1) ic_data_m = rd;
    else          dm_data_m = rd;
    n_total++;
    if (o_mem_req !== 1'b0 || o_ic_ready !== (who == 1) || o_dm_ready !== (who == 2) ||
        o_ic_data !== ic_data_m || o_dm_rdata !== dm_data_m)
      $display("FAIL resp_side%0d: req=%b rdy=%b%b ic_data=%h dm_rdata=%h, required req=0 rdy=%b%b ic_data=%h dm_rdata=%h",
               who, o_mem_req, o_ic_ready, o_dm_ready, o_ic_data, o_dm_rdata,
               who == 1, who == 2, ic_data_m, dm_data_m);
    else n_pass++;
    if (who == 1) i_ic_req = 1'b0;
    else          i_dm_req = 1'b0;
    i_mem_ready = 1'($urandom);
    i_mem_rdata = $urandom;
    last_dm_m   = (who == 2);
    if (who == 2) lock_m = e_lock;
    step();
    i_mem_ready = 1'b0;
    n_total++;
    if (o_mem_req !== 1'b0 || o_ic_ready !== 1'b0 || o_dm_ready !== 1'b0 ||
        o_ic_data !== ic_data_m || o_dm_rdata !== dm_data_m)
      $display("FAIL idle_after_side%0d: req=%b rdy=%b%b ic_data=%h dm_rdata=%h, required req=0 rdy=00 ic_data=%h dm_rdata=%h",
               who, o_mem_req, o_ic_ready, o_dm_ready, o_ic_data, o_dm_rdata, ic_data_m, dm_data_m);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (o_mem_req !== 1'b0 || o_mem_wen !== 1'b0 || o_mem_addr !== '0 || o_mem_wd !== '0 ||
        o_mem_f3 !== '0 || o_ic_ready !== 1'b0 || o_dm_ready !== 1'b0 || o_ic_data !== '0 || o_dm_rdata !== '0)
      $display("FAIL reset_outputs: req=%b wen=%b addr=%h wd=%h f3=%b rdy=%b%b ic_data=%h dm_rdata=%h, required all 0",
               o_mem_req, o_mem_wen, o_mem_addr, o_mem_wd, o_mem_f3, o_ic_ready, o_dm_ready, o_ic_data, o_dm_rdata);
    else n_pass++;
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_ic_fetch();
    i_ic_req  = 1'b1;
    i_ic_addr = 32'h0000_0100;
    run_grant(0, 32'h0050_0093);
  endtask

  task automatic test_dm_write_wait();
    set_dm(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3'b010, 1'b0);
    run_grant(3, $urandom);
  endtask

  task automatic test_idle_ready();
    for (int c = 0; c < 3; c++) begin
      i_mem_ready = 1'b1;
      i_mem_rdata = $urandom;
      step();
      n_total++;
      if (o_mem_req !== 1'b0 || o_ic_ready !== 1'b0 || o_dm_ready !== 1'b0)
        $display("FAIL idle_mem_ready_c%0d: req=%b rdy=%b%b, required req=0 rdy=00",
                 c, o_mem_req, o_ic_ready, o_dm_ready);
      else n_pass++;
    end
    i_mem_ready = 1'b0;
  endtask

  task automatic test_lock();
    set_dm(1'b0, 32'h0000_3000, '0, 3'b010, 1'b1);
    run_grant(1, $urandom);
    i_ic_req  = 1'b1;
    i_ic_addr = 32'h0000_0200;
    run_grant(0, $urandom);
    set_dm(1'b1, 32'h0000_3000, 32'h1234_5678, 3'b010, 1'b0);
    run_grant(0, $urandom);
    run_grant(2, $urandom);
  endtask

  task automatic test_reset_midtxn();
    set_dm(1'b0, 32'h0000_4000, '0, 3'b001, 1'b0);
    step();
    n_total++;
    if (o_mem_req !== 1'b1) $display("FAIL midrst_busy: mem_req=%b, required 1", o_mem_req);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (o_mem_req !== 1'b0 || o_dm_ready !== 1'b0 || o_mem_addr !== '0)
      $display("FAIL midrst_async: mem_req=%b dm_ready=%b addr=%h, required 0 0 0", o_mem_req, o_dm_ready, o_mem_addr);
    else n_pass++;
    i_dm_req = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++;
      if (o_mem_req !== 1'b0 || o_ic_ready !== 1'b0 || o_dm_ready !== 1'b0)
        $display("FAIL midrst_after_c%0d: req=%b rdy=%b%b, required req=0 rdy=00", c, o_mem_req, o_ic_ready, o_dm_ready);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    i_ic_req  = 1'b1;
    i_ic_addr = 32'h0000_0300;
    set_dm(1'b0, 32'h0000_5000, '0, 3'b100, 1'b0);
    run_grant(0, $urandom);
    set_dm(1'b1, 32'h0000_5004, 32'hCAFE_F00D, 3'b010, 1'b0);
    run_grant(1, $urandom);
    i_ic_req  = 1'b1;
    i_ic_addr = 32'h0000_0304;
    run_grant(0, $urandom);
    run_grant(0, $urandom);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if (!i_ic_req && $urandom_range(0, 1) == 1) begin
        i_ic_req  = 1'b1;
        i_ic_addr = $urandom;
      end
      if (!i_dm_req && ($urandom_range(0, 1) == 1 || lock_m || !i_ic_req))
        set_dm(1'($urandom), $urandom, $urandom, 3'($urandom), $urandom_range(0, 3) == 0);
      run_grant($urandom_range(0, 3), $urandom);
    end
  endtask

  initial begin
    i_ic_req = 1'b0; i_ic_addr = '0;
    i_dm_req = 1'b0; i_dm_wen = 1'b0; i_dm_addr = '0; i_dm_wd = '0; i_dm_f3 = '0; i_dm_lock = 1'b0;
    i_mem_ready = 1'b0; i_mem_rdata = '0;
    model_reset();
    test_reset();
    test_ic_fetch();
    test_dm_write_wait();
    test_idle_ready();
    test_lock();
    test_reset_midtxn();
    test_round_robin();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
